// File: rtl/base_conv_pkg.sv
// Shared definitions for the base-conversion blocks (digit entry and display).
// Contents: sel encodings, the base_to_bin state enum and the radix constants.
// Optional build macro BASE_TO_BIN_SAT_EN removes the ERR state, because
// overflow then clamps to 255 instead of locking up.
package base_conv_pkg;

  localparam logic [1:0] SEL_OCT = 2'b00;
  localparam logic [1:0] SEL_HEX = 2'b01;
  localparam logic [1:0] SEL_DEC = 2'b10;

  localparam int unsigned BASE_OCT = 8;
  localparam int unsigned BASE_HEX = 16;
  localparam int unsigned BASE_DEC = 10;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    MUL,
    ADD,
    DONE
`ifndef BASE_TO_BIN_SAT_EN
    ,
    ERR
`endif
  } state_t;

endpackage

// File: rtl/base_to_bin_if.sv
// Digit-entry bus between a keypad/switch front end (master) and base_to_bin
// (slave).
//   sel[1:0]       base select (00 oct, 01 hex, 10 dec, 11 reserved)
//   digit[3:0]     offered digit, qualified by digit_valid/digit_ready
//   commit, clear  publish request / synchronous restart
//   bin_out[7:0]   last committed value, bin_valid qualifies it
//   overflow       value exceeded 255
//   invalid_digit  one-cycle pulse for a rejected digit
//   ndigits[1:0]   accepted digit count, saturating at 3
interface base_to_bin_if;
  import base_conv_pkg::*;

  logic [1:0] sel;
  logic [3:0] digit;
  logic       digit_valid;
  logic       digit_ready;
  logic       commit;
  logic       clear;
  logic [7:0] bin_out;
  logic       bin_valid;
  logic       overflow;
  logic       invalid_digit;
  logic [1:0] ndigits;

  modport master (
    output sel, digit, digit_valid, commit, clear,
    input  digit_ready, bin_out, bin_valid, overflow, invalid_digit, ndigits
  );

  modport slave (
    input  sel, digit, digit_valid, commit, clear,
    output digit_ready, bin_out, bin_valid, overflow, invalid_digit, ndigits
  );

endinterface

// File: rtl/base_digit_check.sv
// Combinational digit validity check for the selected base.
//   digit[3:0]  candidate digit
//   sel[1:0]    base select; the reserved code rejects every digit
//   valid       digit is legal in that base
module base_digit_check
  import base_conv_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [1:0] sel,
  output logic       valid
);

  always_comb begin
    valid = 1'b0;
    unique case (sel)
      SEL_OCT: valid = (digit < 4'd8);
      SEL_HEX: valid = 1'b1;
      SEL_DEC: valid = (digit < 4'd10);
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/base_to_bin.sv
// Sequential digit-entry decoder: accumulates octal/hex/decimal digits, one
// per handshake, into an 8-bit binary value with overflow detection.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   base_to_bin_if.slave (digit handshake, commit/clear, results)
// Build macro BASE_TO_BIN_SAT_EN: overflow clamps the value to 255 and entry
// continues; without it overflow parks in ERR until clear/rst.
module base_to_bin
  import base_conv_pkg::*;
(
  input logic          clk,
  input logic          rst,
  base_to_bin_if.slave bus
);

  state_t      state, state_nxt;
  logic [1:0]  sel_q;
  logic [3:0]  digit_q;
  logic [11:0] acc;
  logic [11:0] tmp;
  logic [11:0] sum;
  logic [1:0]  nd_q;
  logic        ovf_q;
  logic        inv_q;
  logic [7:0]  bin_q;
  logic        bv_q;

  logic        xfer;
  logic        fresh;
  logic        entry_st;
  logic [1:0]  sel_eff;
  logic        dig_ok;
  logic        accept;
  logic        reject;
  logic        do_commit;
  logic        ovf_now;

  assign xfer     = bus.digit_valid && bus.digit_ready;
  // IDLE and DONE are where a new number begins, so the live sel applies.
  assign fresh    = (state == IDLE) || (state == DONE);
  assign entry_st = fresh || (state == ENTRY);
  assign sel_eff  = fresh ? bus.sel : sel_q;

  base_digit_check u_check (
    .digit (bus.digit),
    .sel   (sel_eff),
    .valid (dig_ok)
  );

  assign accept    = xfer && entry_st && dig_ok && !bus.clear;
  assign reject    = xfer && entry_st && !dig_ok && !bus.clear;
  // A digit transfer in the same cycle takes precedence over commit.
  assign do_commit = bus.commit && !bus.clear && !xfer &&
                     ((state == IDLE) || (state == ENTRY));
  assign sum       = tmp + {8'd0, digit_q};
  assign ovf_now   = (sum > 12'd255);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, ENTRY, DONE: begin
          if (accept)         state_nxt = MUL;
          else if (do_commit) state_nxt = DONE;
        end
        MUL: state_nxt = ADD;
        ADD: begin
`ifdef BASE_TO_BIN_SAT_EN
          state_nxt = ENTRY;
`else
          state_nxt = ovf_now ? ERR : ENTRY;
`endif
        end
`ifndef BASE_TO_BIN_SAT_EN
        ERR: state_nxt = ERR;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.digit_ready = 1'b1;
    unique case (state)
      MUL, ADD: bus.digit_ready = 1'b0;
      default:  bus.digit_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= SEL_OCT;
      digit_q <= '0;
      acc     <= '0;
      tmp     <= '0;
      nd_q    <= '0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
      bin_q   <= '0;
      bv_q    <= 1'b0;
    end else begin
      inv_q <= reject;
      if (bus.clear) begin
        acc   <= '0;
        nd_q  <= '0;
        ovf_q <= 1'b0;
        bv_q  <= 1'b0;
      end else begin
        unique case (state)
          IDLE, ENTRY, DONE: begin
            if (xfer && fresh) sel_q <= bus.sel;
            if (accept) begin
              digit_q <= bus.digit;
              if (state == DONE) begin
                acc   <= '0;
                nd_q  <= '0;
                ovf_q <= 1'b0;
                bv_q  <= 1'b0;
              end
            end else if (do_commit) begin
              bin_q <= acc[7:0];
              bv_q  <= 1'b1;
            end
          end
          MUL: begin
            // Multiply by the latched radix with shifts only.
            unique case (sel_q)
              SEL_OCT: tmp <= acc << 3;
              SEL_HEX: tmp <= acc << 4;
              SEL_DEC: tmp <= (acc << 3) + (acc << 1);
              default: tmp <= acc;
            endcase
          end
          ADD: begin
            if (nd_q != 2'd3) nd_q <= nd_q + 2'd1;
            if (ovf_now) begin
              ovf_q <= 1'b1;
`ifdef BASE_TO_BIN_SAT_EN
              acc   <= 12'd255;
`else
              acc   <= sum;
`endif
            end else begin
              acc <= sum;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.bin_out       = bin_q;
  assign bus.bin_valid     = bv_q;
  assign bus.overflow      = ovf_q;
  assign bus.invalid_digit = inv_q;
  assign bus.ndigits       = nd_q;

endmodule

// File: doc/base_to_bin.md
# base_to_bin

Sequential digit-entry decoder: accepts one base-8, base-16 or base-10 digit per handshake and accumulates the 8-bit binary value. It is the input-side counterpart of the binary-to-oct/hex/BCD seven-segment display path. It uses the same `sel` encoding, so a keypad or switch front end can feed the ULA's 8-bit operand bus. Values above 255 and digits invalid for the base are detected and flagged.

## Interface
- No parameters; data width fixed at 8 bits, internal accumulator 12 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sel` in 2: base select: 00 octal, 01 hex, 10 decimal, 11 reserved (all digits invalid).
- `digit` in 4: digit value.
- `digit_valid` in 1: digit offered.
- `digit_ready` out 1: block can take a digit; transfer = `digit_valid && digit_ready` at a rising edge.
- `commit` in 1: single-cycle request to publish the accumulated value.
- `clear` in 1: synchronous abort/restart, highest priority after `rst`.
- `bin_out` out 8: last committed value.
- `bin_valid` out 1: `bin_out` holds a committed value for the current number.
- `overflow` out 1: accumulated value exceeded 255.
- `invalid_digit` out 1: one-cycle pulse when a transferred digit is ≥ base or `sel`=11.
- `ndigits` out 2: count of accepted digits, saturates at 3.

## Operation
- States: IDLE (no digits), ENTRY (≥1 digit), MUL (compute acc×base), ADD (add digit), DONE (committed), ERR (overflow, non-saturating build only).
- `sel` is latched on the first digit transfer out of IDLE or DONE. Later `sel` changes are ignored until `clear`, or until the next number starts after DONE.
- Digit validity: digit < 8, 16 or 10 for the latched base; `sel`=11 rejects every digit.
  - An invalid digit completes the handshake and is discarded.
  - `invalid_digit` pulses; state, accumulator and `ndigits` are unchanged.
- Valid digit in IDLE/ENTRY: go to MUL.
  - MUL: tmp = acc×base using shifts only (octal <<3, hex <<4, decimal (acc<<3)+(acc<<1)).
  - ADD: acc = tmp + digit; `ndigits`++ (saturating).
  - If acc > 255, go to ERR with `overflow`=1; otherwise go to ENTRY.
- Valid digit in DONE: starts a new number. Accumulator restarts from 0, `bin_valid` drops, `sel` is relatched, then MUL/ADD as above.
- `commit` in IDLE/ENTRY: `bin_out` = acc[7:0] (0 from IDLE), `bin_valid`=1, go to DONE.
- `commit` is ignored in MUL, ADD, DONE and ERR.
- `commit` together with a digit transfer: the digit wins and `commit` is dropped.
- ERR: `digit_ready`=1, digits are transferred and discarded, `overflow` holds, and only `clear`/`rst` exit.
- `clear` in any state: go to IDLE next cycle.
  - Clears acc, `ndigits`, `bin_valid`, `overflow`, `invalid_digit`; `bin_out` retains its value.
  - A digit transferred in the same cycle as `clear` is discarded.
- Leading zeros are accepted without limit; range is enforced only by the value check.

## Timing
- Reset values: `digit_ready`=1, `bin_out`=0, `bin_valid`=0, `overflow`=0, `invalid_digit`=0, `ndigits`=0, state IDLE, acc=0.
- Digit transferred at edge T0:
  - MUL during T0→T1, ADD during T1→T2.
  - acc, `ndigits` and `overflow` are visible after T2.
  - `digit_ready`=0 for the two cycles after T0, and high again after T2.
  - Throughput is one digit per 3 cycles.
- `invalid_digit` is high for exactly the cycle after the transfer edge; `digit_ready` stays high.
- `commit` sampled at edge T: `bin_out` and `bin_valid` are updated after T.
- `rst` mid-MUL/ADD: all outputs return to reset values immediately; the partial result is lost.

## Configuration
- `BASE_TO_BIN_SAT_EN` defined:
  - On overflow, acc clamps to 255 and `overflow` is set.
  - State returns to ENTRY, so entry and `commit` continue; `commit` publishes 255.
  - ERR state does not exist.
- `BASE_TO_BIN_SAT_EN` undefined: overflow enters ERR as described under Operation.

## Structure
- Package `base_conv_pkg` holds:
  - sel encodings SEL_OCT=2'b00, SEL_HEX=2'b01, SEL_DEC=2'b10, shared with the display converters;
  - the state enum;
  - the base-value constants 8/16/10.
- One sub-module, `base_digit_check`: combinational (digit, latched sel) → valid.

## Test plan
- sel=10, digits 2,5,5, commit → `bin_out`=0xFF, `bin_valid`=1, `ndigits`=3, `overflow`=0.
- sel=01, digits F,F,1 → `overflow`=1 after the third ADD; commit ignored (`bin_valid`=0); clear → IDLE, `overflow`=0.
- sel=00, digit 8 → single-cycle `invalid_digit` pulse, `ndigits`=0; then 3,7,7, commit → 0xFF.
- sel=10, digit 9, switch sel to 01, digit 9, commit → `bin_out`=0x63 (decimal latched); `digit_ready` low exactly 2 cycles per digit.
- Assert `rst` during MUL → all outputs at reset values. Separately, `clear` and `digit_valid` in the same cycle → digit discarded, `ndigits`=0.
- With `BASE_TO_BIN_SAT_EN`: sel=10, digits 3,0,0, commit → `overflow`=1, `bin_out`=0xFF, `bin_valid`=1.
